// File: rtl/exec_stage.sv
// Y86-64 execute stage: ALU, condition codes, jXX/cmovXX condition, E->M pipeline register.
// Define EXEC_PERF_CNT_EN to add the perf_alu_ops / perf_taken event counters.
module exec_stage #(
  parameter int         W     = 64,
  parameter logic [3:0] RNONE = 4'hF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         m_stall,
  input  logic         m_bubble,
  input  logic         set_cc_en,
  input  logic [2:0]   E_stat,
  input  logic [3:0]   E_icode,
  input  logic [3:0]   E_ifun,
  input  logic [W-1:0] E_valC,
  input  logic [W-1:0] E_valA,
  input  logic [W-1:0] E_valB,
  input  logic [3:0]   E_dstE,
  input  logic [3:0]   E_dstM,
  output logic [W-1:0] e_valE,
  output logic [3:0]   e_dstE,
  output logic         e_cnd,
  output logic [2:0]   cc,
  output logic [2:0]   M_stat,
  output logic [3:0]   M_icode,
  output logic         M_cnd,
  output logic [W-1:0] M_valE,
  output logic [W-1:0] M_valA,
  output logic [3:0]   M_dstE,
  output logic [3:0]   M_dstM
`ifdef EXEC_PERF_CNT_EN
  ,
  output logic [31:0]  perf_alu_ops,
  output logic [31:0]  perf_taken
`endif
);

  localparam logic [3:0] I_NOP   = 4'h1;
  localparam logic [3:0] I_RRMOV = 4'h2;
  localparam logic [3:0] I_IRMOV = 4'h3;
  localparam logic [3:0] I_RMMOV = 4'h4;
  localparam logic [3:0] I_MRMOV = 4'h5;
  localparam logic [3:0] I_OPQ   = 4'h6;
  localparam logic [3:0] I_JXX   = 4'h7;
  localparam logic [3:0] I_CALL  = 4'h8;
  localparam logic [3:0] I_RET   = 4'h9;
  localparam logic [3:0] I_PUSH  = 4'hA;
  localparam logic [3:0] I_POP   = 4'hB;
  localparam logic [2:0] S_AOK   = 3'd1;
  localparam logic [W-1:0] STACK_STEP = W'(8);

  logic         of_add, of_sub, new_zf, new_sf, new_of;
  logic         set_cc, cond, load;

  // ALU: operand selection and function folded into one result mux.
  always_comb begin
    e_valE = '0;
    case (E_icode)
      I_RRMOV:          e_valE = E_valA;
      I_IRMOV:          e_valE = E_valC;
      I_RMMOV, I_MRMOV: e_valE = E_valB + E_valC;
      I_OPQ: begin
        case (E_ifun)
          4'h0:    e_valE = E_valB + E_valA;
          4'h1:    e_valE = E_valB - E_valA;
          4'h2:    e_valE = E_valB & E_valA;
          4'h3:    e_valE = E_valB ^ E_valA;
          default: e_valE = '0;
        endcase
      end
      I_CALL, I_PUSH:   e_valE = E_valB - STACK_STEP;
      I_RET, I_POP:     e_valE = E_valB + STACK_STEP;
      default:          e_valE = '0;
    endcase
  end

  assign of_add = (E_valA[W-1] == E_valB[W-1]) && (e_valE[W-1] != E_valB[W-1]);
  assign of_sub = (E_valA[W-1] != E_valB[W-1]) && (e_valE[W-1] != E_valB[W-1]);
  assign new_zf = (e_valE == '0);
  assign new_sf = e_valE[W-1];
  assign new_of = (E_ifun == 4'h0) ? of_add : (E_ifun == 4'h1) ? of_sub : 1'b0;
  assign set_cc = (E_icode == I_OPQ) && (E_ifun <= 4'h3) && set_cc_en && (E_stat == S_AOK);

  // CC updates regardless of the E->M register's stall/bubble state.
  always_ff @(posedge clk) begin
    if (rst)         cc <= 3'b100;
    else if (set_cc) cc <= {new_zf, new_sf, new_of};
  end

  // Condition is evaluated against the CC value before this instruction's update.
  always_comb begin
    cond = 1'b0;
    case (E_ifun)
      4'h0: cond = 1'b1;
      4'h1: cond = (cc[1] ^ cc[0]) | cc[2];
      4'h2: cond = cc[1] ^ cc[0];
      4'h3: cond = cc[2];
      4'h4: cond = ~cc[2];
      4'h5: cond = ~(cc[1] ^ cc[0]);
      4'h6: cond = ~(cc[1] ^ cc[0]) & ~cc[2];
      default: cond = 1'b0;
    endcase
  end

  assign e_cnd  = ((E_icode == I_RRMOV) || (E_icode == I_JXX)) ? cond : 1'b0;
  assign e_dstE = ((E_icode == I_RRMOV) && !e_cnd) ? RNONE : E_dstE;
  assign load   = !rst && !m_stall && !m_bubble;

  always_ff @(posedge clk) begin
    if (rst || (!m_stall && m_bubble)) begin
      M_stat  <= S_AOK;
      M_icode <= I_NOP;
      M_cnd   <= 1'b0;
      M_valE  <= '0;
      M_valA  <= '0;
      M_dstE  <= RNONE;
      M_dstM  <= RNONE;
    end else if (load) begin
      M_stat  <= E_stat;
      M_icode <= E_icode;
      M_cnd   <= e_cnd;
      M_valE  <= e_valE;
      M_valA  <= E_valA;
      M_dstE  <= e_dstE;
      M_dstM  <= E_dstM;
    end
  end

`ifdef EXEC_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_alu_ops <= '0;
      perf_taken   <= '0;
    end else if (load) begin
      if (E_icode == I_OPQ)          perf_alu_ops <= perf_alu_ops + 32'd1;
      if ((E_icode == I_JXX) && e_cnd) perf_taken <= perf_taken + 32'd1;
    end
  end
`endif

endmodule
